branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Execute-side counterpart to the fetch-stage predictor and control-hazard logic.
- Holds in-flight branch predictions in order and compares each with the execute-stage outcome.
- Drives the predictor training update (update/taken) and the mispredict flush plus redirect PC back to fetch.
- Produces the flush, update and actual-outcome signals the pipeline currently ties off or feeds from a testbench pin.

Parameters:
- DEPTH, 4: in-flight branch queue entries; power of two, 2..8.
- FLUSH_CYCLES, 2: cycles flush is held high after a mispredict; 1..7.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pred_valid  in  1  fetch issued a branch this cycle, with its prediction
- pred_pc  in  8  PC of predicted branch
- pred_taken  in  1  predictor direction
- pred_target  in  8  predicted target (meaningful when pred_taken=1)
- pred_ready  out  1  queue can accept a prediction this cycle
- res_valid  in  1  execute resolved the oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  8  actual target (meaningful when res_taken=1)
- update  out  1  one-cycle predictor-training pulse
- update_pc  out  8  PC being trained
- update_taken  out  1  actual direction being trained
- flush  out  1  squash fetch/decode/execute younger instructions
- redirect_pc  out  8  correct fetch PC; valid while flush=1
- occupancy  out  3  current queue entry count

Behaviour:
- Reset (async, immediate):
  - Queue empty, occupancy=0, FSM=RUN.
  - update=0, update_pc=0, update_taken=0.
  - flush=0, redirect_pc=0, pred_ready=1.
- Queue:
  - Circular FIFO with wr_ptr, rd_ptr and a count; pointers wrap modulo DEPTH.
  - pred_ready = (state==RUN) && (count<DEPTH). This is combinational from registered state only.
  - A push occurs when pred_valid && pred_ready.
  - When pred_valid && !pred_ready: input is dropped, no state change.
- Resolution:
  - A pop occurs when res_valid && count>0 && state==RUN. It compares against the head entry.
  - res_valid with an empty queue, or during FLUSH: ignored, no update, no flush.
- Mispredict rule:
  - Mispredict when (pred_taken != res_taken), or when (pred_taken && res_taken && pred_target != res_target).
- Outputs, registered, appearing the cycle after the pop edge (1-cycle latency):
  - Every pop: update=1 for exactly one cycle; update_pc=head.pc, update_taken=res_taken.
  - Correct prediction: flush stays 0.
  - Mispredict: flush=1 and redirect_pc = res_taken ? res_target : head.pc+1 (8-bit wrap, 0xFF+1=0x00).
- Simultaneous push and pop, correct prediction: both take effect; count unchanged.
- Simultaneous push and pop, mispredict: the push is discarded because it is younger than the branch.
- FSM:
  - RUN -> FLUSH on a mispredicting pop. In the same edge, the whole queue is cleared (count=0, wr_ptr=rd_ptr=0) and the flush counter is loaded with FLUSH_CYCLES.
  - FLUSH: flush=1 and redirect_pc is held. The counter decrements each cycle. At the edge where it would reach 0, go to RUN and set flush=0.
  - flush is therefore high for exactly FLUSH_CYCLES cycles.
  - update is high only in the first FLUSH cycle.
- Reset asserted mid-FLUSH: immediate return to reset values, with no completion of the flush window.
- No combinational path from any input to any output except none; pred_ready depends on registered state only.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
  - stat_branches increments on every pop; stat_mispredicts increments on every mispredicting pop.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Correct not-taken: push pc=0x10, pred_taken=0; next cycle res_valid, res_taken=0 -> one cycle later update=1, update_pc=0x10, update_taken=0, flush=0, occupancy=0.
- Direction mispredict: push pc=0x20, pred_taken=0; resolve res_taken=1, res_target=0x40 -> flush=1 for 2 cycles, redirect_pc=0x40, update=1 for 1 cycle, pred_ready=0 during flush.
- Target mispredict plus wrap: push pc=0xFF, taken, target 0x05; resolve taken, target 0x06 -> redirect_pc=0x06. Separately, pc=0xFF predicted taken, resolved not-taken -> redirect_pc=0x00.
- Full/flush squash:
  - Push 4 branches -> occupancy=4, pred_ready=0, and a 5th pred_valid is dropped.
  - Mispredict on the head, with simultaneous pred_valid -> queue cleared, occupancy=0.
  - After the flush ends, the next resolution returns update only for newly pushed entries.
- Edge inputs: res_valid with an empty queue -> no update/flush. Async reset asserted mid-FLUSH -> flush=0 and occupancy=0 immediately without a clock edge.
- With BRU_STATS_EN: 3 correct and 2 mispredicted resolutions -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: in-order queue of predictions, training updates, mispredict flush.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pred_valid,
   input  logic [7:0] pred_pc,
   input  logic       pred_taken,
   input  logic [7:0] pred_target,
   output logic       pred_ready,
   input  logic       res_valid,
   input  logic       res_taken,
   input  logic [7:0] res_target,
   output logic       update,
   output logic [7:0] update_pc,
   output logic       update_taken,
   output logic       flush,
   output logic [7:0] redirect_pc,
   output logic [2:0] occupancy
`ifdef BRU_STATS_EN
   ,
   output logic [15:0] stat_branches,
   output logic [15:0] stat_mispredicts
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t             state, state_nxt;
   logic [2:0]         fcnt, fcnt_nxt;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [3:0]         count;
   logic [7:0]         q_pc     [DEPTH];
   logic               q_taken  [DEPTH];
   logic [7:0]         q_target [DEPTH];

   logic               push, pop, mispredict;
   logic [7:0]         head_pc, head_target;
   logic               head_taken;

`ifdef BRU_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   always_comb begin
      head_pc     = q_pc[rd_ptr];
      head_taken  = q_taken[rd_ptr];
      head_target = q_target[rd_ptr];
      pred_ready  = (state == RUN) && (count < 4'(DEPTH));
      pop         = res_valid && (count != 4'd0) && (state == RUN);
      mispredict  = pop && ((head_taken != res_taken) ||
                            (head_taken && res_taken && (head_target != res_target)));
      // A push in the same cycle as a mispredict is younger than the branch and is squashed.
      push        = pred_valid && pred_ready && !mispredict;
   end

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      case (state)
         RUN: begin
            if (mispredict) begin
               state_nxt = FLUSH;
               fcnt_nxt  = 3'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (fcnt <= 3'd1) begin
               state_nxt = RUN;
               fcnt_nxt  = 3'd0;
            end else begin
               fcnt_nxt  = fcnt - 3'd1;
            end
         end
         default: begin
            state_nxt = RUN;
            fcnt_nxt  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         fcnt         <= 3'd0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= 4'd0;
         update       <= 1'b0;
         update_pc    <= 8'd0;
         update_taken <= 1'b0;
         redirect_pc  <= 8'd0;
      end else begin
         state  <= state_nxt;
         fcnt   <= fcnt_nxt;
         update <= pop;
         if (pop) begin
            update_pc    <= head_pc;
            update_taken <= res_taken;
         end
         if (mispredict) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 4'd0;
            redirect_pc <= res_taken ? res_target : head_pc + 8'd1;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {3'b000, push} - {3'b000, pop};
         end
      end
   end

   // Queue payload carries no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]     <= pred_pc;
         q_taken[wr_ptr]  <= pred_taken;
         q_target[wr_ptr] <= pred_target;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches    <= 16'd0;
         stat_mispredicts <= 16'd0;
      end else begin
         if (pop)        stat_branches    <= sat_inc(stat_branches);
         if (mispredict) stat_mispredicts <= sat_inc(stat_mispredicts);
      end
   end
`endif

   assign flush     = (state == FLUSH);
   // A full 8-deep queue cannot be shown in 3 bits; it reads as 7.
   assign occupancy = count[3] ? 3'd7 : count[2:0];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-level reference model checked every cycle.
module tb_branch_resolve_unit;
   localparam int DEPTH = 4;
   localparam int FC    = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       pred_valid, pred_taken, res_valid, res_taken;
   logic [7:0] pred_pc, pred_target, res_target;
   logic       pred_ready, update, update_taken, flush;
   logic [7:0] update_pc, redirect_pc;
   logic [2:0] occupancy;
`ifdef BRU_STATS_EN
   logic [15:0] stat_branches, stat_mispredicts;
`endif

   branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .update(update), .update_pc(update_pc), .update_taken(update_taken),
      .flush(flush), .redirect_pc(redirect_pc), .occupancy(occupancy)
`ifdef BRU_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of outstanding predictions plus a flush countdown.
   typedef struct {
      logic [7:0] pc;
      logic       t;
      logic [7:0] tg;
   } ent_t;

   ent_t       mq[$];
   ent_t       h;
   int         m_flush_left = 0;
   logic       m_update = 1'b0;
   logic [7:0] m_upc = 8'd0;
   logic       m_ut = 1'b0;
   logic [7:0] m_redir = 8'd0;
   int         m_sb = 0, m_sm = 0;
   bit         m_mis, m_ready;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_flush_left = 0;
         m_update = 1'b0; m_upc = 8'd0; m_ut = 1'b0; m_redir = 8'd0;
         m_sb = 0; m_sm = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
         m_update = 1'b0;
      end else begin
         m_mis    = 1'b0;
         m_ready  = (mq.size() < DEPTH);
         m_update = 1'b0;
         if (res_valid && mq.size() > 0) begin
            h = mq.pop_front();
            m_mis = (h.t != res_taken) || (h.t && h.tg != res_target);
            m_update = 1'b1;
            m_upc = h.pc;
            m_ut = res_taken;
            m_sb++;
            if (m_mis) begin
               mq.delete();
               m_flush_left = FC;
               m_redir = res_taken ? res_target : h.pc + 8'd1;
               m_sm++;
            end
         end
         if (pred_valid && m_ready && !m_mis)
            mq.push_back('{pc: pred_pc, t: pred_taken, tg: pred_target});
      end
   end

   always @(negedge clk) begin
      chk("pred_ready", pred_ready, (m_flush_left == 0 && mq.size() < DEPTH));
      chk("occupancy", occupancy, 16'(mq.size()));
      chk("update", update, m_update);
      chk("update_pc", update_pc, m_upc);
      chk("update_taken", update_taken, m_ut);
      chk("flush", flush, m_flush_left > 0);
      chk("redirect_pc", redirect_pc, m_redir);
`ifdef BRU_STATS_EN
      chk("stat_branches", stat_branches, 16'(m_sb));
      chk("stat_mispredicts", stat_mispredicts, 16'(m_sm));
`endif
   end

   task automatic drv(input logic pv, input logic [7:0] ppc, input logic pt, input logic [7:0] ptg,
                      input logic rv, input logic rt, input logic [7:0] rtg);
      pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
      res_valid = rv; res_taken = rt; res_target = rtg;
   endtask

   task automatic idle();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic one_branch(input logic [7:0] pc, input logic pt, input logic rt);
      drv(1'b1, pc, pt, 8'hA0, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, rt, 8'hA0); tick();
      idle(); tick(); tick(); tick();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick(); tick();
      chk("rst_ready", pred_ready, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_flush", flush, 0);
      reset = 1'b0;

      // Correct not-taken
      drv(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00); tick();
      chk("t1_update", update, 1);
      chk("t1_upc", update_pc, 16'h10);
      chk("t1_ut", update_taken, 0);
      chk("t1_flush", flush, 0);
      chk("t1_occ", occupancy, 0);
      idle(); tick();

      // Direction mispredict
      drv(1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40); tick();
      chk("t2_flush1", flush, 1);
      chk("t2_redir", redirect_pc, 16'h40);
      chk("t2_update1", update, 1);
      chk("t2_ready1", pred_ready, 0);
      idle(); tick();
      chk("t2_flush2", flush, 1);
      chk("t2_update2", update, 0);
      chk("t2_ready2", pred_ready, 0);
      tick();
      chk("t2_flush_end", flush, 0);
      chk("t2_ready_end", pred_ready, 1);

      // Target mispredict, then not-taken redirect wrapping past 0xFF
      drv(1'b1, 8'hFF, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06); tick();
      chk("t3_redir_tgt", redirect_pc, 16'h06);
      idle(); tick(); tick();
      drv(1'b1, 8'hFF, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00); tick();
      chk("t3_redir_wrap", redirect_pc, 16'h00);
      chk("t3_flush", flush, 1);
      idle(); tick(); tick();

      // Fill, simultaneous push/pop, overflow drop, squash on mispredict
      for (int i = 1; i <= 3; i++) begin
         drv(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      end
      chk("t4_occ3", occupancy, 3);
      drv(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00); tick();
      chk("t4_pushpop_occ", occupancy, 3);
      chk("t4_pushpop_upc", update_pc, 16'h01);
      drv(1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      chk("t4_full_occ", occupancy, 4);
      chk("t4_full_ready", pred_ready, 0);
      drv(1'b1, 8'h06, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      chk("t4_drop_occ", occupancy, 4);
      drv(1'b1, 8'h07, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80); tick();
      chk("t4_squash_occ", occupancy, 0);
      chk("t4_squash_redir", redirect_pc, 16'h80);
      chk("t4_squash_upc", update_pc, 16'h02);
      idle(); tick(); tick();
      drv(1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00); tick();
      chk("t4_new_upc", update_pc, 16'h30);
      chk("t4_new_update", update, 1);
      chk("t4_new_flush", flush, 0);
      idle(); tick();

      // Resolution with empty queue, then async reset mid-flush
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55); tick();
      chk("t5_empty_update", update, 0);
      chk("t5_empty_flush", flush, 0);
      drv(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); tick();
      drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44); tick();
      chk("t5_in_flush", flush, 1);
      idle();
      #2 reset = 1'b1;
      #1;
      chk("t5_async_flush", flush, 0);
      chk("t5_async_occ", occupancy, 0);
      chk("t5_async_redir", redirect_pc, 0);
      chk("t5_async_update", update, 0);
      tick();
      reset = 1'b0;
      tick();

`ifdef BRU_STATS_EN
      one_branch(8'h11, 1'b0, 1'b0);
      one_branch(8'h12, 1'b1, 1'b1);
      one_branch(8'h13, 1'b0, 1'b1);
      one_branch(8'h14, 1'b0, 1'b0);
      one_branch(8'h15, 1'b1, 1'b0);
      chk("stats_branches", stat_branches, 16'd5);
      chk("stats_mispredicts", stat_mispredicts, 16'd2);
`else
      one_branch(8'h11, 1'b1, 1'b1);
      chk("t6_upc", update_pc, 16'h11);
      chk("t6_ut", update_taken, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
